// File: rtl/rx_pkg.sv
// Shared types and default sizes for the receive unstuff/shift stage.
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    ERROR = 2'd2
  } rx_us_state_t;

  localparam int unsigned RX_DATA_W    = 8;
  localparam int unsigned RX_STUFF_LEN = 6;

endpackage

// File: rtl/rx_unstuff_shifter_if.sv
// Serial-in / byte-out bundle between the NRZI decoder side and the receive controller.
// Optional align_err signal exists when RX_ALIGN_ERR_EN is defined.
interface rx_unstuff_shifter_if
  import rx_pkg::*;
#(
  parameter int unsigned DATA_W = RX_DATA_W
);

  logic              d_orig;
  logic              shift_enable;
  logic              eop;
  logic              rcving;
  logic [DATA_W-1:0] rx_data;
  logic              byte_valid;
  logic              stuff_err;
`ifdef RX_ALIGN_ERR_EN
  logic              align_err;
`endif

  modport master (
    output d_orig, shift_enable, eop, rcving,
    input  rx_data, byte_valid, stuff_err
`ifdef RX_ALIGN_ERR_EN
    , input align_err
`endif
  );

  modport slave (
    input  d_orig, shift_enable, eop, rcving,
    output rx_data, byte_valid, stuff_err
`ifdef RX_ALIGN_ERR_EN
    , output align_err
`endif
  );

endinterface

// File: rtl/rx_bit_counter.sv
// Clearable up-counter with enable; flags when the count equals TERM. Clear wins over enable.
module rx_bit_counter #(
  parameter int unsigned W    = 4,
  parameter int unsigned TERM = 7
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic at_term_c
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + W'(1);
  end

  assign at_term_c = (cnt == W'(TERM));

endmodule

// File: rtl/rx_unstuff_shifter.sv
// Removes USB stuffed bits from the decoded stream and assembles LSB-first bytes.
// Build option RX_ALIGN_ERR_EN adds an align_err pulse for eop arriving mid-byte.
module rx_unstuff_shifter
  import rx_pkg::*;
#(
  parameter int unsigned DATA_W    = RX_DATA_W,
  parameter int unsigned STUFF_LEN = RX_STUFF_LEN
) (
  input logic                  clk,
  input logic                  n_rst,
  rx_unstuff_shifter_if.slave  bus
);

  localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
  localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);

  rx_us_state_t      state;
  logic [DATA_W-1:0] shift_q;
  logic              bit_last_c;
  logic              stuff_slot_c;
  logic              rcv_c;
  logic              bit_ev_c;
  logic              eop_ev_c;
  logic              data_ev_c;
  logic              byte_done_c;
  logic [DATA_W-1:0] shift_nxt_c;

  assign rcv_c        = (state == RECV) && bus.rcving;
  assign bit_ev_c     = rcv_c && bus.shift_enable && !bus.eop;
  assign eop_ev_c     = rcv_c && bus.shift_enable && bus.eop;
  assign data_ev_c    = bit_ev_c && !stuff_slot_c;
  assign byte_done_c  = data_ev_c && bit_last_c;
  assign shift_nxt_c  = {bus.d_orig, shift_q[DATA_W-1:1]};

  // Data bits in the current byte; terminal flag marks the last bit slot.
  rx_bit_counter #(.W(BIT_W), .TERM(DATA_W - 1)) u_bit_cnt (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (!bus.rcving || eop_ev_c || byte_done_c),
    .en        (data_ev_c),
    .at_term_c (bit_last_c)
  );

  // Run of consecutive 1s; carries across byte boundaries.
  rx_bit_counter #(.W(ONES_W), .TERM(STUFF_LEN)) u_ones_cnt (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (!bus.rcving || eop_ev_c || (bit_ev_c && !bus.d_orig)),
    .en        (data_ev_c && bus.d_orig),
    .at_term_c (stuff_slot_c)
  );

`ifdef RX_ALIGN_ERR_EN
  logic partial_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      partial_q     <= 1'b0;
      bus.align_err <= 1'b0;
    end else begin
      bus.align_err <= eop_ev_c && partial_q;
      if (!bus.rcving || eop_ev_c || byte_done_c) partial_q <= 1'b0;
      else if (data_ev_c)                         partial_q <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state          <= IDLE;
      shift_q        <= '0;
      bus.rx_data    <= '0;
      bus.byte_valid <= 1'b0;
      bus.stuff_err  <= 1'b0;
    end else begin
      bus.byte_valid <= 1'b0;
      if (!bus.rcving) begin
        state         <= IDLE;
        bus.stuff_err <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= RECV;
          RECV: begin
            if (data_ev_c) shift_q <= shift_nxt_c;
            if (byte_done_c) begin
              bus.rx_data    <= shift_nxt_c;
              bus.byte_valid <= 1'b1;
            end
            // A 1 in the stuff slot is a protocol violation; park until rcving drops.
            if (bit_ev_c && stuff_slot_c && bus.d_orig) begin
              bus.stuff_err <= 1'b1;
              state         <= ERROR;
            end
          end
          ERROR:   state <= ERROR;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_unstuff_shifter.sv
// Bench for rx_unstuff_shifter: an encoder-side bit stuffer builds streams, received bytes are compared with sent bytes.
module tb_rx_unstuff_shifter;
  import rx_pkg::*;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  rx_unstuff_shifter_if bus ();
  rx_unstuff_shifter dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [7:0] got_q[$];
  int align_cnt = 0;

  always @(negedge clk) begin
    if (bus.byte_valid === 1'b1) got_q.push_back(bus.rx_data);
`ifdef RX_ALIGN_ERR_EN
    if (bus.align_err === 1'b1) align_cnt++;
`endif
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    bus.rcving = 1'b0;
    idle(1);
    bus.rcving = 1'b1;
    idle(1);
  endtask

  task automatic send_bit(input bit b, input int gap);
    bus.d_orig       = b;
    bus.eop          = 1'b0;
    bus.shift_enable = 1'b1;
    @(negedge clk);
    bus.shift_enable = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_eop();
    bus.d_orig       = 1'b0;
    bus.eop          = 1'b1;
    bus.shift_enable = 1'b1;
    @(negedge clk);
    bus.shift_enable = 1'b0;
    bus.eop          = 1'b0;
  endtask

  // Transmitter-side view: emit bytes LSB-first, inserting a 0 after every six 1s.
  task automatic encode(input logic [7:0] bytes[$], inout int run, output bit bits[$]);
    logic [7:0] v;
    bits = {};
    foreach (bytes[k]) begin
      v = bytes[k];
      for (int i = 0; i < 8; i++) begin
        bits.push_back(v[i]);
        if (v[i]) run++; else run = 0;
        if (run == 6) begin
          bits.push_back(1'b0);
          run = 0;
        end
      end
    end
  endtask

  task automatic send_bits(input bit bits[$], input int gap);
    foreach (bits[k]) send_bit(bits[k], gap);
  endtask

  task automatic check_bytes(input string name, input logic [7:0] exp_q[$]);
    total++;
    if (got_q.size() !== exp_q.size()) begin
      bad++;
      $display("FAIL %s count: got %0d expected %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[k]) begin
        total++;
        if (got_q[k] !== exp_q[k]) begin
          bad++;
          $display("FAIL %s byte%0d: got %h expected %h", name, k, got_q[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.rcving = 1'b0; bus.shift_enable = 1'b0; bus.eop = 1'b0; bus.d_orig = 1'b0;
    idle(2);
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset rx_data: got %h expected 00", bus.rx_data); end
    total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL reset byte_valid: got %b expected 0", bus.byte_valid); end
    total++; if (bus.stuff_err !== 1'b0) begin bad++; $display("FAIL reset stuff_err: got %b expected 0", bus.stuff_err); end
`ifdef RX_ALIGN_ERR_EN
    total++; if (bus.align_err !== 1'b0) begin bad++; $display("FAIL reset align_err: got %b expected 0", bus.align_err); end
`endif
    n_rst = 1'b1;
    idle(1);
  endtask

  task automatic test_single_byte();
    logic [7:0] v = 8'hA5;
    logic [7:0] exp_q[$];
    restart();
    got_q.delete();
    for (int i = 0; i < 8; i++) send_bit(v[i], (i == 7) ? 0 : 7);
    total++; if (bus.byte_valid !== 1'b1) begin bad++; $display("FAIL a5 latency: byte_valid %b expected 1", bus.byte_valid); end
    total++; if (bus.rx_data !== 8'hA5) begin bad++; $display("FAIL a5 data: got %h expected a5", bus.rx_data); end
    idle(1);
    total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL a5 pulse width: byte_valid %b expected 0", bus.byte_valid); end
    total++; if (bus.stuff_err !== 1'b0) begin bad++; $display("FAIL a5 stuff_err: got %b expected 0", bus.stuff_err); end
    idle(2);
    exp_q.push_back(8'hA5);
    check_bytes("a5", exp_q);
  endtask

  task automatic test_stuffed_ff();
    logic [7:0] exp_q[$];
    bit bits[$];
    int run = 0;
    restart();
    got_q.delete();
    exp_q.push_back(8'hFF);
    encode(exp_q, run, bits);
    send_bits(bits, 1);
    idle(2);
    check_bytes("ff_stuffed", exp_q);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    bit bits[$];
    int run = 0;
    restart();
    got_q.delete();
    exp_q.push_back(8'hF0);
    exp_q.push_back(8'h03);
    encode(exp_q, run, bits);
    send_bits(bits, 0);
    idle(2);
    check_bytes("f0_03", exp_q);
    total++; if (bus.stuff_err !== 1'b0) begin bad++; $display("FAIL f0_03 stuff_err: got %b expected 0", bus.stuff_err); end
  endtask

  task automatic test_stuff_err();
    logic [7:0] v = 8'h3C;
    logic [7:0] exp_q[$];
    restart();
    got_q.delete();
    for (int i = 0; i < 7; i++) send_bit(1'b1, 0);
    total++; if (bus.stuff_err !== 1'b1) begin bad++; $display("FAIL stuff_err set: got %b expected 1", bus.stuff_err); end
    for (int i = 0; i < 8; i++) send_bit(v[i], 1);
    send_eop();
    idle(2);
    check_bytes("in_error", exp_q);
    total++; if (bus.stuff_err !== 1'b1) begin bad++; $display("FAIL stuff_err sticky: got %b expected 1", bus.stuff_err); end
    bus.rcving = 1'b0;
    idle(1);
    total++; if (bus.stuff_err !== 1'b0) begin bad++; $display("FAIL stuff_err clear: got %b expected 0", bus.stuff_err); end
    bus.rcving = 1'b1;
    idle(1);
  endtask

  task automatic test_eop_partial();
    logic [7:0] exp_q[$];
    bit bits[$];
    int run = 0;
    int a0;
    restart();
    got_q.delete();
    a0 = align_cnt;
    send_bit(1'b1, 1); send_bit(1'b0, 1); send_bit(1'b1, 1);
    send_eop();
    total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL eop byte_valid: got %b expected 0", bus.byte_valid); end
    exp_q.push_back(8'h3C);
    encode(exp_q, run, bits);
    send_bits(bits, 2);
    idle(2);
    check_bytes("after_eop", exp_q);
`ifdef RX_ALIGN_ERR_EN
    total++; if (align_cnt - a0 !== 1) begin bad++; $display("FAIL align_err pulses: got %0d expected 1", align_cnt - a0); end
`endif
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_q[$];
    bit bits[$];
    int run = 0;
    restart();
    got_q.delete();
    for (int i = 0; i < 5; i++) send_bit(i == 0, 0);
    #2 n_rst = 1'b0;
    #1;
    total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL midreset rx_data: got %h expected 00", bus.rx_data); end
    total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL midreset byte_valid: got %b expected 0", bus.byte_valid); end
    total++; if (bus.stuff_err !== 1'b0) begin bad++; $display("FAIL midreset stuff_err: got %b expected 0", bus.stuff_err); end
    @(negedge clk);
    n_rst = 1'b1;
    idle(1);
    exp_q.push_back(8'h81);
    encode(exp_q, run, bits);
    send_bits(bits, 1);
    idle(2);
    check_bytes("after_reset", exp_q);
  endtask

  task automatic test_rcving_wins();
    logic [7:0] exp_q[$];
    restart();
    got_q.delete();
    for (int i = 0; i < 7; i++) send_bit(1'b0, 0);
    bus.d_orig = 1'b0; bus.shift_enable = 1'b1; bus.rcving = 1'b0;
    @(negedge clk);
    bus.shift_enable = 1'b0;
    total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL rcving_wins byte_valid: got %b expected 0", bus.byte_valid); end
    bus.rcving = 1'b1;
    idle(3);
    check_bytes("rcving_wins", exp_q);
  endtask

  task automatic test_random();
    logic [7:0] all_q[$];
    logic [7:0] pkt[$];
    bit bits[$];
    int run = 0;
    int a0;
    restart();
    got_q.delete();
    a0 = align_cnt;
    for (int p = 0; p < 8; p++) begin
      pkt = {};
      for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
        // Bias toward 0xFF-heavy bytes so stuff slots land at many offsets.
        pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
      end
      foreach (pkt[k]) all_q.push_back(pkt[k]);
      encode(pkt, run, bits);
      foreach (bits[k]) send_bit(bits[k], $urandom_range(0, 3));
      send_eop();
      run = 0;
      idle($urandom_range(0, 2));
    end
    idle(2);
    check_bytes("random", all_q);
    total++; if (bus.stuff_err !== 1'b0) begin bad++; $display("FAIL random stuff_err: got %b expected 0", bus.stuff_err); end
`ifdef RX_ALIGN_ERR_EN
    total++; if (align_cnt !== a0) begin bad++; $display("FAIL random align_err: got %0d pulses expected 0", align_cnt - a0); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stuffed_ff();
    test_back_to_back();
    test_stuff_err();
    test_eop_partial();
    test_reset_mid();
    test_rcving_wins();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_unstuff_shifter.md
Name: rx_unstuff_shifter

Overview:
Receive-path stage directly downstream of the NRZI decoder.
- Consumes the decoded serial bit stream (d_orig), qualified by shift_enable and eop.
- Removes USB stuffed bits (a 0 inserted after six consecutive 1s).
- Assembles LSB-first data bytes and presents each byte with a one-cycle valid strobe.
- Flags bit-stuffing violations to the receive controller.

Parameters:
- DATA_W, 8, bits per assembled word.
- STUFF_LEN, 6, consecutive 1s after which the next bit is a stuffed bit.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- d_orig  input  1  decoded serial bit from the NRZI decoder.
- shift_enable  input  1  one-cycle strobe; d_orig is valid this cycle.
- eop  input  1  end-of-packet indication, sampled with shift_enable.
- rcving  input  1  packet-active from the receive controller; low forces IDLE.
- rx_data  output  DATA_W  last completed byte, LSB = first bit received.
- byte_valid  output  1  one-cycle pulse; a new byte is on rx_data.
- stuff_err  output  1  sticky bit-stuffing violation flag.

Behaviour:
- Reset (n_rst low, asynchronous): state=IDLE, shift reg=0, bit_cnt=0, ones_cnt=0, rx_data=0, byte_valid=0, stuff_err=0.
- States: IDLE, RECV, ERROR.
- IDLE -> RECV when rcving=1. Any state -> IDLE when rcving=0; that cycle clears bit_cnt, ones_cnt and stuff_err. rx_data is retained.
- A "bit event" is shift_enable=1 & eop=0 in RECV. shift_enable=0 means hold everything.
- Bit event with ones_cnt==STUFF_LEN (stuff slot):
  - d_orig=0: bit discarded, ones_cnt<=0, bit_cnt unchanged.
  - d_orig=1: stuff_err<=1, state<=ERROR, bit discarded.
- Any other bit event:
  - shift reg <= {d_orig, shift reg[DATA_W-1:1]}, i.e. shift right with the new bit into the MSB.
  - bit_cnt++.
  - ones_cnt <= d_orig ? ones_cnt+1 : 0.
- Byte completion: when bit_cnt reaches DATA_W on a bit event, next cycle rx_data <= the completed word, byte_valid=1 for exactly one cycle, bit_cnt <= 0.
- Latency: byte_valid asserts the clock after the shift_enable of the last data bit.
- ones_cnt carries across byte boundaries. A stuff slot at byte start is handled normally.
- eop with shift_enable in RECV: no shift; bit_cnt<=0, ones_cnt<=0; stay in RECV. A partial byte is dropped, with no byte_valid.
- ERROR: all bit events and eop are ignored, byte_valid stays 0, stuff_err stays 1 until rcving=0.
- rcving=0 coincident with a final bit event: rcving wins; no byte_valid.
- Counter widths: bit_cnt uses $clog2(DATA_W+1) bits and ones_cnt uses $clog2(STUFF_LEN+1) bits, both saturation-free by construction.

Optional Feature:
- Macro: RX_ALIGN_ERR_EN.
- Defined: adds output port align_err (1 bit, reset 0). It pulses for one cycle the clock after an eop/shift_enable event that arrives with bit_cnt != 0 in RECV.
- Undefined: the port is absent and partial bytes are dropped silently.

Decomposition:
- Package rx_pkg holds:
  - typedef enum logic [1:0] rx_us_state_t {IDLE, RECV, ERROR};
  - localparams RX_DATA_W=8 and RX_STUFF_LEN=6, used as parameter defaults.
- One natural sub-module, rx_bit_counter: a clearable up-counter with enable and terminal-count flag, instanced twice (bit_cnt, ones_cnt).

Test Plan:
- 0xA5 sent LSB-first, shift_enable every 8 clocks -> one byte_valid pulse 1 clk after 8th strobe; rx_data=0xA5; stuff_err=0.
- 0xFF sent as bits 1,1,1,1,1,1,0(stuffed),1,1 (9 strobes) -> single byte_valid, rx_data=0xFF; the stuffed 0 is not counted.
- 0xF0 then 0x03, with a stuffed 0 inserted after the 6th consecutive 1 (bit 1 of the second byte) -> rx_data=0xF0 then 0x03, two pulses, stuff_err=0.
- Seven consecutive 1s -> stuff_err=1 on the 7th strobe's next clock; subsequent valid byte yields no byte_valid; rcving low -> stuff_err=0, state IDLE.
- 3 bits then eop+shift_enable -> no byte_valid, bit_cnt=0; next full 0x3C received correctly. With RX_ALIGN_ERR_EN: align_err pulses once.
- n_rst low after 5 bits of a byte -> all outputs 0 immediately; after release, full 0x81 byte received correctly.
